// File: rtl/program_counter_register.sv
// -----------------------------------------------------------------------------
// program_counter_register
//
// Architectural 16-bit program counter (PCH:PCL) for the 8-bit CPU datapath.
// It takes byte loads from the internal data bus, sequential increments and
// signed 8-bit relative branches. A branch that crosses a page updates PCL
// first and then spends one extra cycle (FIX_HIGH) adjusting PCH by +/-1.
//
// Ports:
//   clk           in   1  system clock, rising-edge updates
//   nrst          in   1  asynchronous active-low reset
//   data_in       in   8  byte from the internal data bus for loads
//   load_low      in   1  write data_in into PCL
//   load_high     in   1  write data_in into PCH
//   increment     in   1  PC <= PC + 1 (16-bit, wraps)
//   branch_valid  in   1  start relative branch by branch_offset
//   branch_offset in   8  signed two's-complement displacement
//   pc_low        out  8  current PCL
//   pc_high       out  8  current PCH
//   busy          out  1  high during the PCH fix-up cycle (decoder stalls)
//   page_cross    out  1  combinational pulse in a page-crossing branch cycle
//
// Configuration macro:
//   PC_RESET_VECTOR_EN  defined   -> reset PC = 0xFFFC (reset-vector fetch)
//                       undefined -> reset PC = 0x0000
// -----------------------------------------------------------------------------
module program_counter_register (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] data_in,
  input  logic       load_low,
  input  logic       load_high,
  input  logic       increment,
  input  logic       branch_valid,
  input  logic [7:0] branch_offset,
  output logic [7:0] pc_low,
  output logic [7:0] pc_high,
  output logic       busy,
  output logic       page_cross
);

`ifdef PC_RESET_VECTOR_EN
  localparam logic [7:0] RESET_PCL = 8'hFC;
  localparam logic [7:0] RESET_PCH = 8'hFF;
`else
  localparam logic [7:0] RESET_PCL = 8'h00;
  localparam logic [7:0] RESET_PCH = 8'h00;
`endif

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    FIX_HIGH = 1'b1
  } state_t;

  // A branch crosses a page when the 9-bit unsigned add of PCL and the raw
  // offset byte disagrees with the offset sign: a forward branch that carries
  // out, or a backward branch that does not.
  function automatic logic crosses_page(input logic [7:0] offset,
                                        input logic       carry);
    crosses_page = offset[7] ? ~carry : carry;
  endfunction

  // 16-bit increment across both PC bytes; 0xFFFF wraps to 0x0000.
  function automatic logic [15:0] pc_plus_one(input logic [7:0] hi,
                                              input logic [7:0] lo);
    pc_plus_one = {hi, lo} + 16'd1;
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] pcl_r;
  logic [7:0] pch_r;
  logic       adj_down_r;       // 1: FIX_HIGH decrements PCH, 0: increments
  logic [7:0] pcl_next_s;
  logic [7:0] pch_next_s;
  logic       adj_down_next_s;
  logic [8:0] branch_sum_s;
  logic       any_load_s;
  logic       cross_s;
  logic [15:0] inc_pc_s;

  assign branch_sum_s = {1'b0, pcl_r} + {1'b0, branch_offset};
  assign any_load_s   = load_low | load_high;
  assign cross_s      = crosses_page(branch_offset, branch_sum_s[8]);
  assign inc_pc_s     = pc_plus_one(pch_r, pcl_r);

  // State and PC registers; reset aborts any pending PCH fix-up.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= IDLE;
      pcl_r      <= RESET_PCL;
      pch_r      <= RESET_PCH;
      adj_down_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      pcl_r      <= pcl_next_s;
      pch_r      <= pch_next_s;
      adj_down_r <= adj_down_next_s;
    end
  end

  // Next-state logic: only a page-crossing branch leaves IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!any_load_s && branch_valid && cross_s) begin
          state_next_s = FIX_HIGH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FIX_HIGH: state_next_s = IDLE;
      default:  state_next_s = IDLE;
    endcase
  end

  // PC datapath: loads beat branch, branch beats increment; FIX_HIGH ignores
  // all commands and only adjusts PCH.
  always_comb begin
    pcl_next_s      = pcl_r;
    pch_next_s      = pch_r;
    adj_down_next_s = adj_down_r;
    case (state_r)
      IDLE: begin
        if (any_load_s) begin
          if (load_low) begin
            pcl_next_s = data_in;
          end else begin
            pcl_next_s = pcl_r;
          end
          if (load_high) begin
            pch_next_s = data_in;
          end else begin
            pch_next_s = pch_r;
          end
        end else if (branch_valid) begin
          pcl_next_s = branch_sum_s[7:0];
          if (cross_s) begin
            adj_down_next_s = branch_offset[7];
          end else begin
            adj_down_next_s = adj_down_r;
          end
        end else if (increment) begin
          pch_next_s = inc_pc_s[15:8];
          pcl_next_s = inc_pc_s[7:0];
        end else begin
          pcl_next_s = pcl_r;
          pch_next_s = pch_r;
        end
      end
      FIX_HIGH: begin
        if (adj_down_r) begin
          pch_next_s = pch_r - 8'd1;
        end else begin
          pch_next_s = pch_r + 8'd1;
        end
      end
      default: begin
        pcl_next_s = pcl_r;
        pch_next_s = pch_r;
      end
    endcase
  end

  // Outputs: busy decodes the registered state; page_cross is the
  // combinational crossing flag qualified by an active IDLE branch.
  always_comb begin
    busy       = 1'b0;
    page_cross = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (branch_valid && !any_load_s) begin
          page_cross = cross_s;
        end else begin
          page_cross = 1'b0;
        end
      end
      FIX_HIGH: begin
        busy       = 1'b1;
        page_cross = 1'b0;
      end
      default: begin
        busy       = 1'b0;
        page_cross = 1'b0;
      end
    endcase
  end

  assign pc_low  = pcl_r;
  assign pc_high = pch_r;

endmodule

// File: tb/tb_program_counter_register.sv
// -----------------------------------------------------------------------------
// tb_program_counter_register
//
// Directed self-checking bench for program_counter_register. Each scenario
// task drives commands and compares outputs against hand-computed values.
// Inputs change #1 after a rising edge; outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_program_counter_register;

`ifdef PC_RESET_VECTOR_EN
  localparam logic [15:0] RST_PC = 16'hFFFC;
`else
  localparam logic [15:0] RST_PC = 16'h0000;
`endif

  logic       clk;
  logic       nrst;
  logic [7:0] data_in;
  logic       load_low;
  logic       load_high;
  logic       increment;
  logic       branch_valid;
  logic [7:0] branch_offset;
  logic [7:0] pc_low;
  logic [7:0] pc_high;
  logic       busy;
  logic       page_cross;

  int checks;
  int failures;

  program_counter_register dut (
    .clk           (clk),
    .nrst          (nrst),
    .data_in       (data_in),
    .load_low      (load_low),
    .load_high     (load_high),
    .increment     (increment),
    .branch_valid  (branch_valid),
    .branch_offset (branch_offset),
    .pc_low        (pc_low),
    .pc_high       (pc_high),
    .busy          (busy),
    .page_cross    (page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    data_in       = 8'h00;
    load_low      = 1'b0;
    load_high     = 1'b0;
    increment     = 1'b0;
    branch_valid  = 1'b0;
    branch_offset = 8'h00;
  endtask

  // Apply a command for one clock, then release it #1 after the edge.
  task automatic step(input logic ll, input logic lh, input logic [7:0] d,
                      input logic inc, input logic bv, input logic [7:0] off);
    load_low      = ll;
    load_high     = lh;
    data_in       = d;
    increment     = inc;
    branch_valid  = bv;
    branch_offset = off;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_pc(input logic [15:0] v);
    step(1'b1, 1'b0, v[7:0], 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, v[15:8], 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    checks++;
    if ({pc_high, pc_low} !== RST_PC) begin
      failures++;
      $display("FAIL reset_pc got=%h exp=%h", {pc_high, pc_low}, RST_PC);
    end
    checks++;
    if (busy !== 1'b0 || page_cross !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%b pc=%b exp 0 0", busy, page_cross);
    end
  endtask

  task automatic test_load();
    step(1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({pc_high, pc_low} !== 16'h3434) begin
      failures++;
      $display("FAIL load_both got=%h exp=3434", {pc_high, pc_low});
    end
    step(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({pc_high, pc_low} !== 16'h1234) begin
      failures++;
      $display("FAIL load_high got=%h exp=1234", {pc_high, pc_low});
    end
    // Load wins over a crossing branch: no page_cross, no FIX_HIGH.
    set_pc(16'h12F0);
    load_low = 1'b1; data_in = 8'h77; branch_valid = 1'b1; branch_offset = 8'h20;
    #1;
    checks++;
    if (page_cross !== 1'b0) begin
      failures++;
      $display("FAIL load_prio_pc got=%b exp=0", page_cross);
    end
    @(posedge clk); #1; clear_inputs();
    checks++;
    if ({pc_high, pc_low} !== 16'h1277 || busy !== 1'b0) begin
      failures++;
      $display("FAIL load_prio got=%h busy=%b exp=1277 busy=0", {pc_high, pc_low}, busy);
    end
  endtask

  task automatic test_increment();
    set_pc(16'h12FF);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({pc_high, pc_low} !== 16'h1300) begin
      failures++;
      $display("FAIL inc_carry got=%h exp=1300", {pc_high, pc_low});
    end
    set_pc(16'hFFFF);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({pc_high, pc_low} !== 16'h0000) begin
      failures++;
      $display("FAIL inc_wrap got=%h exp=0000", {pc_high, pc_low});
    end
    set_pc(16'h12FF);
    step(1'b1, 1'b0, 8'hAA, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({pc_high, pc_low} !== 16'h12AA) begin
      failures++;
      $display("FAIL inc_with_load got=%h exp=12AA", {pc_high, pc_low});
    end
  endtask

  task automatic test_branch_no_cross();
    set_pc(16'h1210);
    branch_valid = 1'b1; branch_offset = 8'h05;
    #1;
    checks++;
    if (page_cross !== 1'b0) begin
      failures++;
      $display("FAIL fwd_nocross_pc got=%b exp=0", page_cross);
    end
    @(posedge clk); #1; clear_inputs();
    checks++;
    if ({pc_high, pc_low} !== 16'h1215 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fwd_nocross got=%h busy=%b exp=1215 busy=0", {pc_high, pc_low}, busy);
    end
    set_pc(16'h1210);
    branch_valid = 1'b1; branch_offset = 8'hF0;
    #1;
    checks++;
    if (page_cross !== 1'b0) begin
      failures++;
      $display("FAIL bwd_nocross_pc got=%b exp=0", page_cross);
    end
    @(posedge clk); #1; clear_inputs();
    checks++;
    if ({pc_high, pc_low} !== 16'h1200 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bwd_nocross got=%h busy=%b exp=1200 busy=0", {pc_high, pc_low}, busy);
    end
  endtask

  task automatic test_forward_cross();
    set_pc(16'h12F0);
    branch_valid = 1'b1; branch_offset = 8'h20;
    #1;
    checks++;
    if (page_cross !== 1'b1) begin
      failures++;
      $display("FAIL fwd_cross_pulse got=%b exp=1", page_cross);
    end
    @(posedge clk); #1; clear_inputs();
    checks++;
    if ({pc_high, pc_low} !== 16'h1210 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fwd_cross_c1 got=%h busy=%b exp=1210 busy=1", {pc_high, pc_low}, busy);
    end
    // Commands during FIX_HIGH must be ignored and must not raise page_cross.
    increment = 1'b1; load_low = 1'b1; data_in = 8'h55;
    branch_valid = 1'b1; branch_offset = 8'h20;
    #1;
    checks++;
    if (page_cross !== 1'b0) begin
      failures++;
      $display("FAIL fix_no_pulse got=%b exp=0", page_cross);
    end
    @(posedge clk); #1; clear_inputs();
    checks++;
    if ({pc_high, pc_low} !== 16'h1310 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fwd_cross_c2 got=%h busy=%b exp=1310 busy=0", {pc_high, pc_low}, busy);
    end
  endtask

  task automatic test_backward_cross();
    set_pc(16'h0005);
    branch_valid = 1'b1; branch_offset = 8'hF6;
    #1;
    checks++;
    if (page_cross !== 1'b1) begin
      failures++;
      $display("FAIL bwd_cross_pulse got=%b exp=1", page_cross);
    end
    @(posedge clk); #1; clear_inputs();
    checks++;
    if ({pc_high, pc_low} !== 16'h00FB || busy !== 1'b1) begin
      failures++;
      $display("FAIL bwd_cross_c1 got=%h busy=%b exp=00FB busy=1", {pc_high, pc_low}, busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({pc_high, pc_low} !== 16'hFFFB || busy !== 1'b0) begin
      failures++;
      $display("FAIL bwd_cross_c2 got=%h busy=%b exp=FFFB busy=0", {pc_high, pc_low}, busy);
    end
  endtask

  task automatic test_reset_mid_fixup();
    set_pc(16'h12F0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h20);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre_busy got=%b exp=1", busy);
    end
    #1;
    nrst = 1'b0;
    #1;
    checks++;
    if ({pc_high, pc_low} !== RST_PC || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_async got=%h busy=%b exp=%h busy=0", {pc_high, pc_low}, busy, RST_PC);
    end
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({pc_high, pc_low} !== RST_PC || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_release got=%h busy=%b exp=%h busy=0", {pc_high, pc_low}, busy, RST_PC);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    nrst = 1'b0;
    #2;
    test_reset();
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    test_load();
    test_increment();
    test_branch_no_cross();
    test_forward_cross();
    test_backward_cross();
    test_reset_mid_fixup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
